// File: rtl/gray_conv_arbiter_if.sv
// Request/response bundle between requesters and the shared
// Gray converter front-end.
interface gray_conv_arbiter_if #(
  parameter int N   = 4,
  parameter int IDW = 2
);
  logic [N-1:0]   req;
  logic [4*N-1:0] bin_in;
  logic [N-1:0]   gnt;
  logic [3:0]     gray_out;
  logic [IDW-1:0] out_id;
  logic           out_valid;
  logic           busy;
  logic [7:0]     conv_cnt;

  modport master (
    output req,
    output bin_in,
    input  gnt,
    input  gray_out,
    input  out_id,
    input  out_valid,
    input  busy,
    input  conv_cnt
  );

  modport slave (
    input  req,
    input  bin_in,
    output gnt,
    output gray_out,
    output out_id,
    output out_valid,
    output busy,
    output conv_cnt
  );
endinterface

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one 4-bit binary-to-Gray converter
// among N requesters; result returned registered with requester ID.
module bin_gra (
  input  logic b3,
  input  logic b2,
  input  logic b1,
  input  logic b0,
  output logic g3,
  output logic g2,
  output logic g1,
  output logic g0
);
  assign g3 = b3;
  assign g2 = b3 ^ b2;
  assign g1 = b2 ^ b1;
  assign g0 = b1 ^ b0;
endmodule

module gray_conv_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input logic               clk,
  input logic               rst_n,
  gray_conv_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    CONV,
    RESP
  } state_t;

  typedef struct packed {
    logic [3:0]     bin;
    logic [IDW-1:0] id;
  } cap_t;

  localparam logic [N-1:0]   ONE  = N'(1);
  localparam logic [IDW-1:0] LAST = IDW'(N - 1);

  state_t         state;
  cap_t           cap;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] win;
  logic           win_ok;
  logic [3:0]     win_bin;
  logic [3:0]     conv;

  // Search starts one past the last winner so grants rotate.
  always_comb begin
    win     = '0;
    win_ok  = 1'b0;
    win_bin = '0;
    for (int i = 1; i <= N; i++) begin
      if (!win_ok && bus.req[(int'(rr_ptr) + i) % N]) begin
        win_ok = 1'b1;
        win    = IDW'((int'(rr_ptr) + i) % N);
      end
    end
    win_bin = bus.bin_in[4*int'(win) +: 4];
  end

  bin_gra u_conv (
    cap.bin[3], cap.bin[2], cap.bin[1], cap.bin[0],
    conv[3], conv[2], conv[1], conv[0]
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cap           <= '0;
      rr_ptr        <= LAST;
      bus.gnt       <= '0;
      bus.gray_out  <= '0;
      bus.out_id    <= '0;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.conv_cnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (win_ok) begin
            cap.bin  <= win_bin;
            cap.id   <= win;
            bus.gnt  <= ONE << win;
            rr_ptr   <= win;
            bus.busy <= 1'b1;
            state    <= CONV;
          end
        end
        CONV: begin
          bus.gray_out  <= conv;
          bus.out_id    <= cap.id;
          bus.out_valid <= 1'b1;
          bus.gnt       <= '0;
          state         <= RESP;
        end
        RESP: begin
          bus.out_valid <= 1'b0;
          bus.conv_cnt  <= bus.conv_cnt + 8'd1;
          bus.busy      <= 1'b0;
          state         <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed bench for gray_conv_arbiter with a timeline model
// and per-cycle output comparison.
module tb_gray_conv_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  gray_conv_arbiter_if #(.N(N), .IDW(IDW)) bus ();

  gray_conv_arbiter #(.N(N), .IDW(IDW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  int m_edge = 0;
  int m_acc  = -100;
  int m_last = N - 1;
  int m_id   = 0;
  int m_gray = 0;
  int m_cnt  = 0;
  int p_id   = 0;
  int p_gray = 0;

  int cyc = 0;
  int ov_gray[$];
  int ov_id[$];
  int ov_cyc[$];
  int gnt_id[$];

  int exp_tab[16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

  task automatic check(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int gray_of(int b);
    return b ^ (b >> 1);
  endfunction

  function automatic int pick(int last, logic [N-1:0] r);
    for (int i = 1; i <= N; i++)
      if (r[(last + i) % N]) return (last + i) % N;
    return -1;
  endfunction

  // Timeline model: accept at edge A -> gnt after A, result after A+1,
  // count after A+2, next accept no earlier than A+3.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_edge = 0;
        m_acc  = -100;
        m_last = N - 1;
        m_id   = 0;
        m_gray = 0;
        m_cnt  = 0;
      end else begin
        m_edge++;
        if (m_edge == m_acc + 1) begin
          m_gray = p_gray;
          m_id   = p_id;
        end
        if (m_edge == m_acc + 2) m_cnt = (m_cnt + 1) % 256;
        if (m_edge >= m_acc + 3 && bus.req != '0) begin
          p_id   = pick(m_last, bus.req);
          p_gray = gray_of(int'(bus.bin_in[4*p_id +: 4]));
          m_last = p_id;
          m_acc  = m_edge;
        end
      end
    end
  end

  initial begin
    @(negedge rst_n);
    forever begin
      @(negedge clk);
      cyc++;
      check("gnt", int'(bus.gnt), (m_edge == m_acc) ? (1 << p_id) : 0);
      check("out_valid", int'(bus.out_valid), int'(m_edge == m_acc + 1));
      check("busy", int'(bus.busy),
            int'(m_edge == m_acc || m_edge == m_acc + 1));
      check("gray_out", int'(bus.gray_out), m_gray);
      check("out_id", int'(bus.out_id), m_id);
      check("conv_cnt", int'(bus.conv_cnt), m_cnt);
      if (bus.out_valid) begin
        ov_gray.push_back(int'(bus.gray_out));
        ov_id.push_back(int'(bus.out_id));
        ov_cyc.push_back(cyc);
      end
      if (bus.gnt != '0) gnt_id.push_back($clog2(int'(bus.gnt)));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(bit drop = 1'b1);
    @(negedge clk);
    #1;
    if (drop) bus.req = bus.req & ~bus.gnt;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    bus.req    = 4'($urandom_range(15));
    bus.bin_in = 16'($urandom_range(65535));
    repeat (2) @(negedge clk);
    #1;
    bus.req = '0;
    rst_n   = 1'b1;
  endtask

  task automatic wait_resp(string name);
    int n;
    int t;
    n = ov_gray.size();
    t = 0;
    while (ov_gray.size() == n && t < 20) begin
      tick();
      t++;
    end
    check(name, int'(ov_gray.size() > n), 1);
  endtask

  task automatic wait_gnt(string name);
    int t;
    t = 0;
    while (bus.gnt == '0 && t < 20) begin
      tick(1'b0);
      t++;
    end
    check(name, int'(bus.gnt != '0), 1);
  endtask

  initial begin
    int n0;
    int g0;
    bus.req    = '0;
    bus.bin_in = '0;
    #1;

    // reset and idle
    do_reset();
    g0 = gnt_id.size();
    repeat (10) tick();
    check("idle_cnt", int'(bus.conv_cnt), 0);
    check("idle_busy", int'(bus.busy), 0);
    check("idle_no_gnt", gnt_id.size() - g0, 0);

    // single conversion
    bus.bin_in = 16'h0B00;
    bus.req    = 4'b0100;
    wait_resp("single_resp");
    check("single_gray", ov_gray[$], 14);
    check("single_id", ov_id[$], 2);
    check("single_gnt", gnt_id[$], 2);
    tick();
    check("single_cnt", int'(bus.conv_cnt), 1);

    // round robin
    do_reset();
    bus.bin_in = 16'h3210;
    n0 = ov_gray.size();
    bus.req = 4'hF;
    for (int t = 0; t < 40 && ov_gray.size() < n0 + 5; t++) begin
      @(negedge clk);
      #1;
      bus.req = 4'hF & ~bus.gnt;
    end
    bus.req = '0;
    check("rr_count", ov_gray.size() - n0, 5);
    if (ov_gray.size() >= n0 + 5) begin
      int rid[5];
      int rgr[5];
      rid = '{0, 1, 2, 3, 0};
      rgr = '{0, 1, 3, 2, 0};
      for (int i = 0; i < 5; i++) begin
        check("rr_id", ov_id[n0+i], rid[i]);
        check("rr_gray", ov_gray[n0+i], rgr[i]);
        if (i > 0) check("rr_gap", ov_cyc[n0+i] - ov_cyc[n0+i-1], 3);
      end
    end
    repeat (3) tick();

    // exhaustive function on requester 1
    do_reset();
    for (int b = 0; b < 16; b++) begin
      bus.bin_in = 16'(b << 4);
      bus.req    = 4'b0010;
      wait_resp("exh_resp");
      check("exh_gray", ov_gray[$], exp_tab[b]);
      check("exh_id", ov_id[$], 1);
    end
    repeat (2) tick();
    check("exh_cnt", int'(bus.conv_cnt), 16);

    // data isolation
    do_reset();
    bus.bin_in = 16'h0005;
    bus.req    = 4'b0001;
    wait_gnt("iso_gnt");
    bus.req    = '0;
    bus.bin_in = 16'h000F;
    wait_resp("iso_resp");
    check("iso_gray", ov_gray[$], 7);
    repeat (2) tick();

    // reset during CONV
    do_reset();
    bus.bin_in = 16'h0009;
    bus.req    = 4'b0001;
    wait_gnt("rst_gnt");
    n0 = ov_gray.size();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_gnt_low", int'(bus.gnt), 0);
    check("rst_ov_low", int'(bus.out_valid), 0);
    check("rst_busy_low", int'(bus.busy), 0);
    bus.req = '0;
    repeat (3) @(negedge clk);
    check("rst_no_ov", ov_gray.size() - n0, 0);
    #1;
    rst_n      = 1'b1;
    bus.bin_in = 16'h0003;
    bus.req    = 4'b0001;
    wait_gnt("rst_regnt");
    check("rst_gnt_0", int'(bus.gnt), 1);
    bus.req = '0;
    wait_resp("rst_resp");
    check("rst_gray", ov_gray[$], 2);
    repeat (2) tick();

    // counter wrap
    do_reset();
    bus.bin_in = 16'h0000;
    n0 = ov_gray.size();
    bus.req = 4'b0001;
    for (int t = 0; t < 1000 && ov_gray.size() < n0 + 256; t++) tick(1'b0);
    check("wrap_count", ov_gray.size() - n0, 256);
    check("wrap_pre", int'(bus.conv_cnt), 255);
    bus.req = '0;
    tick();
    check("wrap_cnt", int'(bus.conv_cnt), 0);
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
